// File: rtl/reg_wb_scheduler.sv
// Arbitrates the register file write port between pipeline writeback and a
// buffered long-latency result stream, with a per-register busy scoreboard.
module reg_wb_scheduler #(
  parameter int REG_ADDR_W    = 5,
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int LL_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
  input  logic [DATA_W-1:0]     pipe_wb_data,
  output logic                  pipe_stall,
  input  logic                  ll_issue_valid,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  output logic                  ll_issue_ready,
  input  logic                  ll_res_valid,
  input  logic [REG_ADDR_W-1:0] ll_res_rd,
  input  logic [DATA_W-1:0]     ll_res_data,
  output logic                  ll_res_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  output logic                  dec_hazard,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_wdata
);

  // state     | meaning
  // PIPE_PRIO | pipeline owns the write port, FIFO drains when pipe is idle
  // LL_FORCE  | FIFO head forced onto the port, pipeline stalled one cycle
  typedef enum logic {PIPE_PRIO, LL_FORCE} state_t;

  localparam int PTR_W = $clog2(LL_FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t                state;
  logic [NUM_REGS-1:0]   busy;
  logic [CNT_W-1:0]      starve_cnt;
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [REG_ADDR_W-1:0] fifo_rd   [LL_FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data [LL_FIFO_DEPTH];

  logic                  empty, full, push, pop, grant_pipe, issue_acc;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_rd    = fifo_rd[rd_ptr[PTR_W-1:0]];
  assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];

  assign grant_pipe = (state == PIPE_PRIO) && pipe_wb_valid;
  assign pop        = !empty && ((state == LL_FORCE) || !pipe_wb_valid);
  // A full FIFO still accepts a result in a cycle that frees its head
  assign ll_res_ready = !full || pop;
  assign push       = ll_res_valid && ll_res_ready;

  assign ll_issue_ready = !busy[ll_issue_rd];
  assign issue_acc      = ll_issue_valid && ll_issue_ready;
  assign pipe_stall     = (state == LL_FORCE);
  assign dec_hazard     = (busy[dec_rs1] && (dec_rs1 != '0)) ||
                          (busy[dec_rs2] && (dec_rs2 != '0));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[PTR_W-1:0]]   <= ll_res_rd;
      fifo_data[wr_ptr[PTR_W-1:0]] <= ll_res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PIPE_PRIO;
      busy       <= '0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (pop) busy[head_rd] <= 1'b0;
      if (issue_acc && (ll_issue_rd != '0)) busy[ll_issue_rd] <= 1'b1;

      rf_we <= 1'b0;
      if (grant_pipe) begin
        rf_we    <= (pipe_wb_rd != '0);
        rf_rd    <= pipe_wb_rd;
        rf_wdata <= pipe_wb_data;
      end else if (pop) begin
        rf_we    <= (head_rd != '0);
        rf_rd    <= head_rd;
        rf_wdata <= head_data;
      end

      case (state)
        PIPE_PRIO: begin
          if (!empty && !pop) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) state <= LL_FORCE;
          end else begin
            starve_cnt <= '0;
          end
        end
        LL_FORCE: begin
          starve_cnt <= '0;
          state      <= PIPE_PRIO;
        end
        default: state <= PIPE_PRIO;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler: expected register-file writes are queued
// when stimulus is driven and compared in order as rf_we appears.
module tb_reg_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_rd;
  logic        ll_issue_ready;
  logic        ll_res_valid;
  logic [4:0]  ll_res_rd;
  logic [31:0] ll_res_data;
  logic        ll_res_ready;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        dec_hazard;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int          checks = 0;
  int          errors = 0;
  logic [37:0] exp_q[$];
  logic [31:0] tb_busy;
  logic [31:0] d;

  reg_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .ll_issue_valid(ll_issue_valid), .ll_issue_rd(ll_issue_rd), .ll_issue_ready(ll_issue_ready),
    .ll_res_valid(ll_res_valid), .ll_res_rd(ll_res_rd), .ll_res_data(ll_res_data),
    .ll_res_ready(ll_res_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_hazard(dec_hazard),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({1'b1, rd, data});
  endtask

  // Mid-cycle monitor, then advance to just after the next rising edge
  task automatic cyc;
    logic [37:0] e;
    @(negedge clk);
    if (rf_we) begin
      e = (exp_q.size() == 0) ? 38'd0 : exp_q.pop_front();
      chk("sb_write", {rf_we, rf_rd, rf_wdata}, e);
    end
    if (!rst && pipe_wb_valid)
      chk("pipe_to_busy", 64'(tb_busy[pipe_wb_rd] && (pipe_wb_rd != 5'd0)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    ll_issue_valid = 1'b1;
    ll_issue_rd    = rd;
    if (rd != 5'd0) tb_busy[rd] = 1'b1;
    #1 chk("issue_ready", ll_issue_ready, 1);
    cyc;
    ll_issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tb_busy = '0;
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    ll_issue_valid = 0; ll_issue_rd = 0;
    ll_res_valid = 0; ll_res_rd = 0; ll_res_data = 0;
    dec_rs1 = 0; dec_rs2 = 0;
    repeat (3) cyc;
    rst = 1'b0;

    // reset state
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_res_ready", ll_res_ready, 1);
    for (int r = 0; r < 32; r += 7) begin
      dec_rs1 = 5'(r); dec_rs2 = 5'(31 - r);
      #1 chk("rst_hazard", dec_hazard, 0);
    end
    dec_rs1 = 0; dec_rs2 = 0;
    cyc;

    // issue, hazard, result drained with pipe idle
    issue(5'd5);
    dec_rs1 = 5'd5;
    #1 chk("hazard_set", dec_hazard, 1);
    ll_res_valid = 1; ll_res_rd = 5'd5; ll_res_data = 32'hDEAD;
    expect_wr(5'd5, 32'hDEAD);
    cyc;
    ll_res_valid = 0;
    #1 chk("hazard_in_fifo", dec_hazard, 1);
    cyc;
    chk("wr_dead_we", rf_we, 1);
    chk("hazard_clear", dec_hazard, 0);
    dec_rs1 = 0;
    cyc;

    // starvation: forced grant after STARVE_LIMIT waiting cycles
    issue(5'd9);
    d = 32'hA0;
    for (int k = 0; k <= 6; k++) begin
      pipe_wb_valid = 1; pipe_wb_rd = 5'd10; pipe_wb_data = d;
      ll_res_valid = (k == 0); ll_res_rd = 5'd9; ll_res_data = 32'h1234;
      #1 chk("starve_stall", pipe_stall, 64'(k == 5));
      if (k == 5) expect_wr(5'd9, 32'h1234);
      else begin expect_wr(5'd10, d); d++; end
      cyc;
    end
    pipe_wb_valid = 0; ll_res_valid = 0;
    repeat (2) cyc;

    // full FIFO, push with pop while full, order across pointer wrap
    issue(5'd11); issue(5'd12); issue(5'd14);
    for (int k = 0; k <= 6; k++) begin
      pipe_wb_valid = 1; pipe_wb_rd = 5'd13; pipe_wb_data = d;
      ll_res_valid = (k == 0) || (k == 1) || (k == 5);
      ll_res_rd   = (k == 0) ? 5'd11 : (k == 1) ? 5'd12 : 5'd14;
      ll_res_data = (k == 0) ? 32'h11 : (k == 1) ? 32'h12 : 32'h14;
      #1 chk("full_stall", pipe_stall, 64'(k == 5));
      if (k == 2) chk("full_not_ready", ll_res_ready, 0);
      if (k == 5) chk("full_pop_ready", ll_res_ready, 1);
      if (k == 5) expect_wr(5'd11, 32'h11);
      else begin expect_wr(5'd13, d); d++; end
      cyc;
    end
    pipe_wb_valid = 0; ll_res_valid = 0;
    expect_wr(5'd12, 32'h12);
    expect_wr(5'd14, 32'h14);
    repeat (4) cyc;

    // rd 0 issue/result, re-issue to busy register
    ll_issue_valid = 1; ll_issue_rd = 5'd0;
    #1 chk("rd0_ready", ll_issue_ready, 1);
    cyc;
    ll_issue_valid = 0;
    #1 chk("rd0_hazard", dec_hazard, 0);
    ll_res_valid = 1; ll_res_rd = 5'd0; ll_res_data = 32'h55;
    cyc;
    ll_res_valid = 0;
    cyc;
    chk("rd0_no_we", rf_we, 0);
    issue(5'd7);
    ll_issue_valid = 1; ll_issue_rd = 5'd7;
    #1 chk("busy_refused", ll_issue_ready, 0);
    ll_issue_valid = 0;
    dec_rs2 = 5'd7;
    #1 chk("hazard_rs2", dec_hazard, 1);
    cyc;

    // reset with buffered results and busy registers
    issue(5'd8); issue(5'd15);
    for (int k = 0; k <= 1; k++) begin
      pipe_wb_valid = 1; pipe_wb_rd = 5'd3; pipe_wb_data = d;
      ll_res_valid = 1; ll_res_rd = (k == 0) ? 5'd7 : 5'd8; ll_res_data = 32'h77 + 32'(k);
      expect_wr(5'd3, d); d++;
      cyc;
    end
    rst = 1; pipe_wb_valid = 0; ll_res_valid = 0;
    cyc;
    rst = 0; tb_busy = '0;
    dec_rs1 = 5'd7; dec_rs2 = 5'd8; ll_issue_rd = 5'd15;
    #1;
    chk("rst2_hazard", dec_hazard, 0);
    chk("rst2_issue_ready", ll_issue_ready, 1);
    chk("rst2_res_ready", ll_res_ready, 1);
    chk("rst2_stall", pipe_stall, 0);
    for (int k = 0; k < 4; k++) begin
      cyc;
      chk("rst2_no_we", rf_we, 0);
    end

    chk("sb_drain", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
